// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch engine feeding a two-entry queue of {instr, pc+2}
//   toward the IF/ID latch.
// Latency: request in cycle N, response in cycle M>N, instr_valid from cycle M+1.
//   Peak throughput is one instruction every two cycles.
// Backpressure: instr_ready pops the head; fetching stops while the queue is full,
//   a request is outstanding, or the engine is halted.
// Ports: clk/rst (sync, active high); redirect_valid/redirect_pc restart fetch;
//   imem_req/imem_addr and imem_rvalid/imem_rdata talk to instruction memory;
//   instr_valid/instr/instr_pc_plus2/instr_ready form the queue head; err is sticky.
module fetch_queue #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    output logic        instr_valid,
    output logic [15:0] instr,
    output logic [15:0] instr_pc_plus2,
    input  logic        instr_ready,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT      = 2'd1,
        WAIT_KILL = 2'd2,
        HALTED    = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] fetch_pc;
    logic [1:0]  count;

    // Slot 0 is always the head, so the outputs come straight from registers.
    logic [15:0] head_instr;
    logic [15:0] head_pc2;
    logic [15:0] tail_instr;
    logic [15:0] tail_pc2;

    logic push;
    logic pop;
    logic is_halt;

    assign imem_req  = (state == IDLE) && (count != 2'd2) && !redirect_valid && !rst;
    assign imem_addr = fetch_pc;

    assign instr_valid    = (count != 2'd0);
    assign instr          = head_instr;
    assign instr_pc_plus2 = head_pc2;

    assign push    = (state == WAIT) && imem_rvalid && !redirect_valid;
    assign pop     = instr_valid && instr_ready;
    assign is_halt = (imem_rdata[15:11] == 5'b00000);

    always_comb begin
        state_nxt = state;
        if (redirect_valid) begin
            // A response still in flight must be swallowed when it arrives.
            if ((state == WAIT || state == WAIT_KILL) && !imem_rvalid) begin
                state_nxt = WAIT_KILL;
            end else begin
                state_nxt = IDLE;
            end
        end else begin
            case (state)
                IDLE:      if (imem_req)    state_nxt = WAIT;
                WAIT:      if (imem_rvalid) state_nxt = is_halt ? HALTED : IDLE;
                WAIT_KILL: if (imem_rvalid) state_nxt = IDLE;
                default:   state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            count      <= 2'd0;
            err        <= 1'b0;
            head_instr <= 16'h0000;
            head_pc2   <= 16'h0000;
            tail_instr <= 16'h0000;
            tail_pc2   <= 16'h0000;
        end else begin
            state <= state_nxt;

            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[15:1], 1'b0};
            end else if (imem_req) begin
                fetch_pc <= fetch_pc + 16'd2;
            end

            if ((imem_rvalid && (state == IDLE || state == HALTED)) ||
                (redirect_valid && redirect_pc[0])) begin
                err <= 1'b1;
            end

            // While a request is outstanding fetch_pc already holds its
            // address + 2 and cannot move without a redirect, so it is the
            // pc+2 to store. A push only ever meets count<=1 except when
            // paired with a pop, since issue needs count<2 and only one
            // request can be in flight.
            if (redirect_valid) begin
                count <= 2'd0;
            end else begin
                case ({push, pop})
                    2'b11: begin
                        if (count == 2'd1) begin
                            head_instr <= imem_rdata;
                            head_pc2   <= fetch_pc;
                        end else begin
                            head_instr <= tail_instr;
                            head_pc2   <= tail_pc2;
                            tail_instr <= imem_rdata;
                            tail_pc2   <= fetch_pc;
                        end
                    end
                    2'b10: begin
                        if (count == 2'd0) begin
                            head_instr <= imem_rdata;
                            head_pc2   <= fetch_pc;
                        end else begin
                            tail_instr <= imem_rdata;
                            tail_pc2   <= fetch_pc;
                        end
                        count <= count + 2'd1;
                    end
                    2'b01: begin
                        head_instr <= tail_instr;
                        head_pc2   <= tail_pc2;
                        count      <= count - 2'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: self-checking bench for fetch_queue with directed scenarios
//   and a randomized run against a queue-based reference model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_fetch_queue;

    localparam logic [15:0] RST_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc_plus2;
    logic        instr_ready = 1'b0;
    logic        err;

    int checks = 0;
    int errors = 0;

    fetch_queue #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc_plus2 (instr_pc_plus2),
        .instr_ready    (instr_ready),
        .err            (err)
    );

    always #5 clk = ~clk;

    // Instruction memory: one pending read, answered after a latency.
    logic [15:0] mem [0:65535];
    bit          mem_busy = 1'b0;
    int          mem_left = 0;
    logic [15:0] mem_a = 16'h0000;
    int          mem_lat = 1;
    bit          mem_rand = 1'b0;

    // Reference model: queue of {instr, pc+2} plus fetch bookkeeping.
    logic [31:0] m_q[$];
    logic [15:0] m_pc = RST_PC;
    logic [15:0] m_last = 16'h0000;
    bit          m_out = 1'b0;   // a response is still expected
    bit          m_kill = 1'b0;  // that response must be thrown away
    bit          m_halt = 1'b0;
    bit          m_err = 1'b0;
    bit          exp_req = 1'b0;

    // Apply this cycle's inputs (called on a falling edge), then settle.
    task automatic drive(input bit r, input bit rd, input logic [15:0] rpc, input bit rdy);
        rst            = r;
        redirect_valid = rd;
        redirect_pc    = rpc;
        instr_ready    = rdy;
        imem_rvalid    = 1'b0;
        imem_rdata     = 16'($urandom);
        if (mem_busy) begin
            if (mem_left <= 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem[mem_a];
                mem_busy    = 1'b0;
            end else begin
                mem_left--;
            end
        end
        exp_req = !r && !rd && !m_out && !m_halt && (m_q.size() < 2);
        #1;
    endtask

    // Update memory and model with the cycle's events, then move to the next falling edge.
    task automatic advance();
        if (imem_req) begin
            mem_busy = 1'b1;
            mem_left = mem_rand ? int'($urandom_range(1, 3)) : mem_lat;
            mem_a    = imem_addr;
        end
        if (rst) begin
            m_q.delete();
            m_pc   = RST_PC;
            m_out  = 1'b0;
            m_kill = 1'b0;
            m_halt = 1'b0;
            m_err  = 1'b0;
        end else begin
            if (imem_rvalid && !m_out) m_err = 1'b1;
            if (redirect_valid && redirect_pc[0]) m_err = 1'b1;
            if (redirect_valid) begin
                m_q.delete();
                m_pc   = redirect_pc & 16'hFFFE;
                m_halt = 1'b0;
                if (m_out && !imem_rvalid) begin
                    m_kill = 1'b1;
                end else begin
                    m_out  = 1'b0;
                    m_kill = 1'b0;
                end
            end else begin
                if (m_q.size() > 0 && instr_ready) void'(m_q.pop_front());
                if (m_out && imem_rvalid) begin
                    if (!m_kill) begin
                        m_q.push_back({imem_rdata, m_last + 16'd2});
                        if (imem_rdata[15:11] == 5'b00000) m_halt = 1'b1;
                    end
                    m_out  = 1'b0;
                    m_kill = 1'b0;
                end
                if (exp_req) begin
                    m_out  = 1'b1;
                    m_last = m_pc;
                    m_pc   = m_pc + 16'd2;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        mem_busy = 1'b0;
        mem_rand = 1'b0;
        drive(1'b1, 1'b0, 16'h0000, 1'b1);
        advance();
        drive(1'b1, 1'b0, 16'h0000, 1'b1);
        advance();
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 16'h0000, 1'b1);
        checks++;
        if (imem_req !== 1'b0) begin
            errors++; $display("FAIL rst_req_first: imem_req=%b required 0", imem_req);
        end
        advance();
        drive(1'b1, 1'b1, 16'h1235, 1'b1);
        checks++;
        if (imem_req !== 1'b0) begin
            errors++; $display("FAIL rst_req_held: imem_req=%b required 0", imem_req);
        end
        checks++;
        if (instr_valid !== 1'b0 || instr !== 16'h0000 || instr_pc_plus2 !== 16'h0000 || err !== 1'b0) begin
            errors++;
            $display("FAIL rst_outputs: valid=%b instr=%h pc2=%h err=%b required 0/0000/0000/0",
                     instr_valid, instr, instr_pc_plus2, err);
        end
        advance();
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC || err !== 1'b0) begin
            errors++;
            $display("FAIL rst_first_fetch: req=%b addr=%h err=%b required 1/%h/0",
                     imem_req, imem_addr, err, RST_PC);
        end
        advance();
    endtask

    task automatic test_basic();
        logic [15:0] ra[4];
        logic [31:0] va[4];
        int          rc[4];
        int          vc[4];
        int          nr = 0;
        int          nv = 0;
        do_reset();
        mem_lat = 1;
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, 1'b0, 16'h0000, 1'b1);
            if (imem_req === 1'b1 && nr < 4) begin ra[nr] = imem_addr; rc[nr] = c; nr++; end
            if (instr_valid === 1'b1 && nv < 4) begin va[nv] = {instr, instr_pc_plus2}; vc[nv] = c; nv++; end
            advance();
        end
        checks++;
        if (nr < 2 || ra[0] !== 16'h0000 || ra[1] !== 16'h0002) begin
            errors++; $display("FAIL basic_addr: nreq=%0d a0=%h a1=%h required >=2 0000 0002", nr, ra[0], ra[1]);
        end
        checks++;
        if (nv < 2 || va[0] !== 32'h4000_0002 || va[1] !== 32'h4001_0004) begin
            errors++; $display("FAIL basic_data: nval=%0d v0=%h v1=%h required 40000002 40010004", nv, va[0], va[1]);
        end
        checks++;
        if (nr < 2 || nv < 1 || vc[0] != rc[0] + 2 || rc[1] != rc[0] + 2) begin
            errors++; $display("FAIL basic_timing: req@%0d,%0d valid@%0d required req@0,2 valid@2", rc[0], rc[1], vc[0]);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL basic_err: err=%b required 0", err);
        end
    endtask

    task automatic test_backpressure();
        int nr = 0;
        do_reset();
        mem_lat = 1;
        for (int c = 0; c < 8; c++) begin
            drive(1'b0, 1'b0, 16'h0000, 1'b0);
            if (imem_req === 1'b1) nr++;
            if (c == 7) begin
                checks++;
                if (nr != 2 || imem_req !== 1'b0 || instr_valid !== 1'b1) begin
                    errors++; $display("FAIL bp_full: nreq=%0d req=%b valid=%b required 2/0/1", nr, imem_req, instr_valid);
                end
            end
            advance();
        end
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        checks++;
        if ({instr, instr_pc_plus2} !== {mem[0], 16'h0002} || imem_req !== 1'b0) begin
            errors++; $display("FAIL bp_pop1: instr=%h pc2=%h req=%b required %h/0002/0", instr, instr_pc_plus2, imem_req, mem[0]);
        end
        advance();
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        checks++;
        if ({instr, instr_pc_plus2} !== {mem[2], 16'h0004} || instr_valid !== 1'b1) begin
            errors++; $display("FAIL bp_pop2: valid=%b instr=%h pc2=%h required 1/%h/0004", instr_valid, instr, instr_pc_plus2, mem[2]);
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0004) begin
            errors++; $display("FAIL bp_resume: req=%b addr=%h required 1/0004", imem_req, imem_addr);
        end
        advance();
    endtask

    task automatic test_redirect_kill();
        do_reset();
        mem_lat = 2;
        drive(1'b0, 1'b1, 16'h0006, 1'b1);
        advance();
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0006) begin
            errors++; $display("FAIL kill_req: req=%b addr=%h required 1/0006", imem_req, imem_addr);
        end
        advance();
        drive(1'b0, 1'b1, 16'h0100, 1'b1);
        advance();
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL kill_wait: req=%b valid=%b required 0/0", imem_req, instr_valid);
        end
        advance();
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0100 || err !== 1'b0) begin
            errors++;
            $display("FAIL kill_resume: valid=%b req=%b addr=%h err=%b required 0/1/0100/0",
                     instr_valid, imem_req, imem_addr, err);
        end
        advance();
    endtask

    task automatic test_halt();
        int nr = 0;
        do_reset();
        mem_lat = 1;
        mem[16'h0008] = 16'h0000;
        drive(1'b0, 1'b1, 16'h0008, 1'b1);
        advance();
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0008) begin
            errors++; $display("FAIL halt_req: req=%b addr=%h required 1/0008", imem_req, imem_addr);
        end
        advance();
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        advance();
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        checks++;
        if (instr_valid !== 1'b1 || instr !== 16'h0000 || instr_pc_plus2 !== 16'h000A || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL halt_entry: valid=%b instr=%h pc2=%h req=%b required 1/0000/000a/0",
                     instr_valid, instr, instr_pc_plus2, imem_req);
        end
        advance();
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 1'b0, 16'h0000, 1'b1);
            if (imem_req !== 1'b0) nr++;
            advance();
        end
        checks++;
        if (nr != 0 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL halt_quiet: reqs=%0d valid=%b required 0/0", nr, instr_valid);
        end
        drive(1'b0, 1'b1, 16'h0020, 1'b1);
        advance();
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0020) begin
            errors++; $display("FAIL halt_exit: req=%b addr=%h required 1/0020", imem_req, imem_addr);
        end
        advance();
    endtask

    task automatic test_wrap_err();
        do_reset();
        mem_lat = 1;
        mem[16'hFFFE] = 16'h1234;
        drive(1'b0, 1'b1, 16'hFFFE, 1'b1);
        advance();
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'hFFFE) begin
            errors++; $display("FAIL wrap_req: req=%b addr=%h required 1/fffe", imem_req, imem_addr);
        end
        advance();
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        advance();
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        checks++;
        if (instr_valid !== 1'b1 || instr !== 16'h1234 || instr_pc_plus2 !== 16'h0000 ||
            imem_req !== 1'b1 || imem_addr !== 16'h0000 || err !== 1'b0) begin
            errors++;
            $display("FAIL wrap_next: valid=%b instr=%h pc2=%h req=%b addr=%h err=%b required 1/1234/0000/1/0000/0",
                     instr_valid, instr, instr_pc_plus2, imem_req, imem_addr, err);
        end
        advance();
        drive(1'b0, 1'b1, 16'h0011, 1'b1);
        advance();
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        checks++;
        if (err !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 16'h0010 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL odd_redirect: err=%b req=%b addr=%h valid=%b required 1/1/0010/0",
                     err, imem_req, imem_addr, instr_valid);
        end
        advance();
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        mem_lat = 1;
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        advance();
        drive(1'b1, 1'b1, 16'h0040, 1'b1);
        advance();
        mem_lat = 2;
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        checks++;
        if (instr_valid !== 1'b0 || err !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            errors++;
            $display("FAIL rst_wait: valid=%b err=%b req=%b addr=%h required 0/0/1/%h",
                     instr_valid, err, imem_req, imem_addr, RST_PC);
        end
        advance();
        drive(1'b1, 1'b0, 16'h0000, 1'b1);
        advance();
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        advance();
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL stale_rvalid_err: err=%b required 1", err);
        end
        advance();
    endtask

    task automatic test_random();
        logic [15:0] rpc;
        bit          rd;
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        do_reset();
        mem_rand = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            rd  = ($urandom_range(0, 15) == 0);
            rpc = 16'($urandom) & 16'hFFFE;
            drive(1'b0, rd, rpc, ($urandom_range(0, 3) != 0));
            checks++;
            if (imem_req !== exp_req) begin
                errors++; $display("FAIL rnd_req c%0d: imem_req=%b required %b", c, imem_req, exp_req);
            end
            if (exp_req) begin
                checks++;
                if (imem_addr !== m_pc) begin
                    errors++; $display("FAIL rnd_addr c%0d: imem_addr=%h required %h", c, imem_addr, m_pc);
                end
            end
            checks++;
            if (instr_valid !== (m_q.size() != 0)) begin
                errors++; $display("FAIL rnd_valid c%0d: instr_valid=%b required %b", c, instr_valid, m_q.size() != 0);
            end
            if (m_q.size() != 0) begin
                checks++;
                if ({instr, instr_pc_plus2} !== m_q[0]) begin
                    errors++;
                    $display("FAIL rnd_head c%0d: instr/pc2=%h/%h required %h/%h",
                             c, instr, instr_pc_plus2, m_q[0][31:16], m_q[0][15:0]);
                end
            end
            checks++;
            if (err !== m_err) begin
                errors++; $display("FAIL rnd_err c%0d: err=%b required %b", c, err, m_err);
            end
            advance();
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'(i) | 16'h8000;
        mem[16'h0000] = 16'h4000;
        mem[16'h0002] = 16'h4001;
        @(negedge clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_redirect_kill();
        test_halt();
        test_wrap_err();
        test_reset_in_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
